// File: rtl/calc3_pkg.sv
// Shared types for the calc3 request scheduler: command and response encodings
// and the queued request record.
package calc3_pkg;

    localparam int unsigned NPORTS = 4;
    localparam int unsigned TAGW   = 2;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'b0000,
        CMD_ADD   = 4'b0001,
        CMD_SUB   = 4'b0010,
        CMD_SHL   = 4'b0101,
        CMD_SHR   = 4'b0110,
        CMD_STORE = 4'b1001,
        CMD_FETCH = 4'b1010,
        CMD_BZ    = 4'b1100,
        CMD_BEQ   = 4'b1101
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'b00,
        RESP_OK     = 2'b01,
        RESP_ERR    = 2'b10,
        RESP_INTERR = 2'b11
    } resp_e;

    typedef struct packed {
        cmd_e             cmd;
        logic [3:0]       d1;
        logic [3:0]       d2;
        logic [3:0]       r1;
        logic [31:0]      data;
        logic [TAGW-1:0]  tag;
    } calc3_req_t;

endpackage

// File: rtl/calc3_req_fifo.sv
// Per-port request queue: DEPTH-entry FIFO of calc3_req_t with a
// combinational head.
module calc3_req_fifo
    import calc3_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       c_clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  calc3_req_t wr_data,
    output calc3_req_t rd_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = $clog2(DEPTH);

    calc3_req_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

    overflow_chk: assert property (@(posedge c_clk) disable iff (!reset)
        !(push && full && !pop));

endmodule

// File: rtl/calc3_req_sched.sv
// Round-robin front-end scheduler for the calc3 execution unit: per-port queues,
// duplicate-tag rejection and tagged response routing.
module calc3_req_sched #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned TAGW   = 2
) (
    input  logic                       c_clk,
    input  logic                       reset,
    input  logic [3:0]                 req_cmd  [0:NPORTS-1],
    input  logic [3:0]                 req_d1   [0:NPORTS-1],
    input  logic [3:0]                 req_d2   [0:NPORTS-1],
    input  logic [3:0]                 req_r1   [0:NPORTS-1],
    input  logic [31:0]                req_data [0:NPORTS-1],
    input  logic [TAGW-1:0]            req_tag  [0:NPORTS-1],
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [3:0]                 iss_cmd,
    output logic [3:0]                 iss_d1,
    output logic [3:0]                 iss_d2,
    output logic [3:0]                 iss_r1,
    output logic [31:0]                iss_data,
    output logic [$clog2(NPORTS)-1:0]  iss_port,
    output logic [TAGW-1:0]            iss_tag,
    input  logic                       rsp_valid,
    output logic                       rsp_ready,
    input  logic [$clog2(NPORTS)-1:0]  rsp_port,
    input  logic [TAGW-1:0]            rsp_tag,
    input  logic [1:0]                 rsp_resp,
    input  logic [31:0]                rsp_data,
    output logic [1:0]                 out_resp [0:NPORTS-1],
    output logic [31:0]                out_data [0:NPORTS-1],
    output logic [TAGW-1:0]            out_tag  [0:NPORTS-1],
    output logic                       err_unexp
);

    import calc3_pkg::*;

    localparam int unsigned PW = $clog2(NPORTS);
    typedef logic [PW-1:0] port_t;

    logic [QDEPTH-1:0] outst     [NPORTS];
    logic [QDEPTH-1:0] outst_set [NPORTS];
    logic [QDEPTH-1:0] outst_clr [NPORTS];
    calc3_req_t        q_wr      [NPORTS];
    calc3_req_t        q_head    [NPORTS];
    logic [NPORTS-1:0] q_push, q_pop, q_empty, q_full, reject_now;
    port_t             rr_ptr, grant_port, idx;
    logic              grant_found, load, rsp_accept, rsp_hit;

    for (genvar g = 0; g < NPORTS; g++) begin : g_q
        calc3_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
            .c_clk   (c_clk),
            .reset   (reset),
            .push    (q_push[g]),
            .pop     (q_pop[g]),
            .wr_data (q_wr[g]),
            .rd_data (q_head[g]),
            .empty   (q_empty[g]),
            .full    (q_full[g])
        );
    end

    assign rsp_ready  = !reject_now[rsp_port];
    assign rsp_accept = rsp_valid && rsp_ready;
    assign rsp_hit    = rsp_accept && outst[rsp_port][rsp_tag];
    assign load       = !iss_valid || iss_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_port  = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            idx = rr_ptr + port_t'(i);
            if (!grant_found && !q_empty[idx]) begin
                grant_found = 1'b1;
                grant_port  = idx;
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            reject_now[p] = (req_cmd[p] != '0) && outst[p][req_tag[p]];
            q_push[p]     = (req_cmd[p] != '0) && !outst[p][req_tag[p]] && !q_full[p];
            q_pop[p]      = load && grant_found && (grant_port == port_t'(p));
            q_wr[p]       = '{cmd: cmd_e'(req_cmd[p]), d1: req_d1[p], d2: req_d2[p],
                              r1: req_r1[p], data: req_data[p], tag: req_tag[p]};
            outst_set[p]  = q_push[p] ? (QDEPTH'(1) << req_tag[p]) : '0;
            outst_clr[p]  = (rsp_hit && rsp_port == port_t'(p)) ? (QDEPTH'(1) << rsp_tag) : '0;
        end
    end

    // The head moves into the issue register when granted, so the queue is popped
    // at grant time; the grant is only re-evaluated on a handshake or when idle.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            iss_valid <= 1'b0;
            iss_cmd   <= '0;
            iss_d1    <= '0;
            iss_d2    <= '0;
            iss_r1    <= '0;
            iss_data  <= '0;
            iss_port  <= '0;
            iss_tag   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            iss_valid <= grant_found;
            if (grant_found) begin
                iss_cmd  <= q_head[grant_port].cmd;
                iss_d1   <= q_head[grant_port].d1;
                iss_d2   <= q_head[grant_port].d2;
                iss_r1   <= q_head[grant_port].r1;
                iss_data <= q_head[grant_port].data;
                iss_tag  <= q_head[grant_port].tag;
                iss_port <= grant_port;
                rr_ptr   <= grant_port + 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            err_unexp <= 1'b0;
            for (int unsigned p = 0; p < NPORTS; p++) begin
                outst[p]    <= '0;
                out_resp[p] <= '0;
                out_data[p] <= '0;
                out_tag[p]  <= '0;
            end
        end else begin
            err_unexp <= rsp_accept && !rsp_hit;
            for (int unsigned p = 0; p < NPORTS; p++) begin
                outst[p] <= (outst[p] & ~outst_clr[p]) | outst_set[p];
                if (reject_now[p]) begin
                    out_resp[p] <= RESP_ERR;
                    out_tag[p]  <= req_tag[p];
                    out_data[p] <= '0;
                end else if (rsp_hit && rsp_port == port_t'(p)) begin
                    out_resp[p] <= rsp_resp;
                    out_tag[p]  <= rsp_tag;
                    out_data[p] <= rsp_data;
                end else begin
                    out_resp[p] <= '0;
                    out_tag[p]  <= '0;
                    out_data[p] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc3_req_sched.sv
// Directed bench for calc3_req_sched: table of single-request round trips plus
// hand-written sequences for arbitration, rejects, stalls and reset.
module tb_calc3_req_sched;

    logic        c_clk;
    logic        reset;
    logic [3:0]  req_cmd  [0:3];
    logic [3:0]  req_d1   [0:3];
    logic [3:0]  req_d2   [0:3];
    logic [3:0]  req_r1   [0:3];
    logic [31:0] req_data [0:3];
    logic [1:0]  req_tag  [0:3];
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_cmd, iss_d1, iss_d2, iss_r1;
    logic [31:0] iss_data;
    logic [1:0]  iss_port, iss_tag;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_port, rsp_tag, rsp_resp;
    logic [31:0] rsp_data;
    logic [1:0]  out_resp [0:3];
    logic [31:0] out_data [0:3];
    logic [1:0]  out_tag  [0:3];
    logic        err_unexp;

    int passed = 0;
    int total  = 0;

    calc3_req_sched #(.NPORTS(4), .QDEPTH(4), .TAGW(2)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
        .req_data(req_data), .req_tag(req_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_cmd(iss_cmd), .iss_d1(iss_d1), .iss_d2(iss_d2), .iss_r1(iss_r1),
        .iss_data(iss_data), .iss_port(iss_port), .iss_tag(iss_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_tag(rsp_tag), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .err_unexp(err_unexp)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          port;
        logic [3:0]  cmd, d1, d2, r1;
        logic [31:0] data;
        logic [1:0]  tag;
        logic [1:0]  rsp_code;
        logic [31:0] rsp_dat;
        logic [1:0]  exp_port;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clear_req();
        for (int p = 0; p < 4; p++) begin
            req_cmd[p] = '0; req_d1[p] = '0; req_d2[p] = '0;
            req_r1[p] = '0; req_data[p] = '0; req_tag[p] = '0;
        end
    endtask

    initial begin
        int order_a [4];
        int order_b [4];
        int issues;
        int pulses;
        vec_t v;

        vecs[0] = '{0, 4'h9, 4'h0, 4'h0, 4'h1, 32'h1,          2'b01, 2'b01, 32'h0,          2'd0, 2'b01, 32'h0};
        vecs[1] = '{1, 4'h1, 4'h3, 4'h4, 4'h5, 32'h0,          2'b10, 2'b01, 32'h7,          2'd1, 2'b01, 32'h7};
        vecs[2] = '{2, 4'hA, 4'h2, 4'h0, 4'h6, 32'h0,          2'b11, 2'b10, 32'hDEAD,       2'd2, 2'b10, 32'hDEAD};
        vecs[3] = '{1, 4'h5, 4'h7, 4'h1, 4'h7, 32'h0,          2'b10, 2'b01, 32'h80,         2'd1, 2'b01, 32'h80};
        vecs[4] = '{3, 4'hD, 4'h4, 4'h4, 4'h0, 32'hCAFE_F00D,  2'b00, 2'b11, 32'h1234_5678,  2'd3, 2'b11, 32'h1234_5678};
        order_a = '{0, 1, 2, 3};
        order_b = '{2, 3, 0, 1};

        reset = 1'b0;
        clear_req();
        iss_ready = 1'b1;
        rsp_valid = 1'b0; rsp_port = '0; rsp_tag = '0; rsp_resp = '0; rsp_data = '0;
        repeat (3) @(posedge c_clk);
        #1;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_err_unexp", err_unexp, 0);
        check("rst_rsp_ready", rsp_ready, 1);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("rst_out_resp%0d", p), out_resp[p], 0);
            check($sformatf("rst_out_data%0d", p), out_data[p], 0);
        end
        reset = 1'b1;
        tick();

        // Single-request round trips: capture, issue one edge later, respond.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            req_cmd[v.port] = v.cmd; req_d1[v.port] = v.d1; req_d2[v.port] = v.d2;
            req_r1[v.port] = v.r1; req_data[v.port] = v.data; req_tag[v.port] = v.tag;
            tick();
            clear_req();
            check($sformatf("v%0d_idle", i), iss_valid, 0);
            tick();
            check($sformatf("v%0d_iss_valid", i), iss_valid, 1);
            check($sformatf("v%0d_iss_port", i), iss_port, v.exp_port);
            check($sformatf("v%0d_iss_tag", i), iss_tag, v.tag);
            check($sformatf("v%0d_iss_cmd", i), iss_cmd, v.cmd);
            check($sformatf("v%0d_iss_ops", i), {iss_d1, iss_d2, iss_r1}, {v.d1, v.d2, v.r1});
            check($sformatf("v%0d_iss_data", i), iss_data, v.data);
            rsp_valid = 1'b1; rsp_port = v.exp_port; rsp_tag = v.tag;
            rsp_resp = v.rsp_code; rsp_data = v.rsp_dat;
            #1;
            check($sformatf("v%0d_rsp_ready", i), rsp_ready, 1);
            tick();
            rsp_valid = 1'b0;
            check($sformatf("v%0d_drained", i), iss_valid, 0);
            check($sformatf("v%0d_out_resp", i), out_resp[v.exp_port], v.exp_resp);
            check($sformatf("v%0d_out_tag", i), out_tag[v.exp_port], v.tag);
            check($sformatf("v%0d_out_data", i), out_data[v.exp_port], v.exp_data);
            check($sformatf("v%0d_no_unexp", i), err_unexp, 0);
            tick();
            check($sformatf("v%0d_out_clear", i), out_resp[v.exp_port], 0);
        end

        // Burst on all ports with pointer at 0: grants 0,1,2,3 back to back.
        for (int p = 0; p < 4; p++) begin req_cmd[p] = 4'h1; req_tag[p] = 2'b00; end
        tick();
        clear_req();
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_a%0d_valid", k), iss_valid, 1);
            check($sformatf("rr_a%0d_port", k), iss_port, order_a[k]);
            tick();
        end
        check("rr_a_done", iss_valid, 0);

        // Grant port 1 alone, then a full burst must start at port 2.
        req_cmd[1] = 4'h2; req_tag[1] = 2'b01;
        tick();
        clear_req();
        tick();
        check("rr_single_port", iss_port, 1);
        tick();
        for (int p = 0; p < 4; p++) begin req_cmd[p] = 4'h1; req_tag[p] = 2'b10; end
        tick();
        clear_req();
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_b%0d_port", k), iss_port, order_b[k]);
            check($sformatf("rr_b%0d_tag", k), iss_tag, 2'b10);
            tick();
        end
        check("rr_b_done", iss_valid, 0);

        // Duplicate tag 11 on port 0: second copy is rejected, one issue only.
        req_cmd[0] = 4'h2; req_tag[0] = 2'b11;
        tick();
        tick();
        clear_req();
        check("dup_out_resp", out_resp[0], 2'b10);
        check("dup_out_tag", out_tag[0], 2'b11);
        check("dup_out_data", out_data[0], 0);
        check("dup_iss_port", iss_port, 0);
        check("dup_iss_tag", iss_tag, 2'b11);
        issues = (iss_valid && iss_ready) ? 1 : 0;
        tick();
        check("dup_out_clear", out_resp[0], 0);
        for (int k = 0; k < 3; k++) begin
            if (iss_valid && iss_ready) issues++;
            tick();
        end
        check("dup_issue_count", issues, 1);

        // Stall: fields stay frozen on port 1 while port 3 waits.
        iss_ready = 1'b0;
        req_cmd[1] = 4'h6; req_d1[1] = 4'h9; req_tag[1] = 2'b11;
        req_cmd[3] = 4'hA; req_d2[3] = 4'h5; req_tag[3] = 2'b01;
        tick();
        clear_req();
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall%0d_valid", k), iss_valid, 1);
            check($sformatf("stall%0d_fields", k), {iss_port, iss_tag, iss_cmd, iss_d1},
                  {2'd1, 2'b11, 4'h6, 4'h9});
            if (k < 3) tick();
        end
        iss_ready = 1'b1;
        tick();
        check("stall_next_fields", {iss_valid, iss_port, iss_tag, iss_cmd, iss_d2},
              {1'b1, 2'd3, 2'b01, 4'hA, 4'h5});
        tick();
        check("stall_done", iss_valid, 0);

        // Reject on port 2 blocks a same-cycle response for port 2.
        req_cmd[2] = 4'h1; req_tag[2] = 2'b00;
        rsp_valid = 1'b1; rsp_port = 2'd2; rsp_tag = 2'b00; rsp_resp = 2'b01; rsp_data = 32'h55;
        #1;
        check("rej_rsp_ready_low", rsp_ready, 0);
        tick();
        clear_req();
        check("rej_out_resp", out_resp[2], 2'b10);
        check("rej_out_tag", out_tag[2], 2'b00);
        #1;
        check("rej_rsp_ready_high", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        check("rej_rsp_out_resp", out_resp[2], 2'b01);
        check("rej_rsp_out_data", out_data[2], 32'h55);
        check("rej_rsp_no_unexp", err_unexp, 0);
        tick();
        check("rej_rsp_clear", out_resp[2], 0);

        // Response for a tag never requested is dropped.
        rsp_valid = 1'b1; rsp_port = 2'd0; rsp_tag = 2'b01; rsp_resp = 2'b01; rsp_data = 32'h99;
        tick();
        rsp_valid = 1'b0;
        check("unexp_pulse", err_unexp, 1);
        check("unexp_out_resp", out_resp[0], 0);
        tick();
        check("unexp_pulse_end", err_unexp, 0);

        // Reset with port1/port3 tag 10 in flight; their late responses are unexpected.
        reset = 1'b0;
        tick();
        check("mid_rst_iss_valid", iss_valid, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_rsp_ready", rsp_ready, 1);
        pulses = 0;
        rsp_valid = 1'b1; rsp_port = 2'd1; rsp_tag = 2'b10; rsp_resp = 2'b01; rsp_data = 32'h11;
        tick();
        pulses += err_unexp ? 1 : 0;
        check("late1_out_resp", out_resp[1], 0);
        rsp_port = 2'd3; rsp_tag = 2'b10; rsp_data = 32'h33;
        tick();
        rsp_valid = 1'b0;
        pulses += err_unexp ? 1 : 0;
        check("late3_out_resp", out_resp[3], 0);
        tick();
        check("late_pulse_count", pulses, 2);
        check("late_pulse_end", err_unexp, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
